// File: rtl/fr_normalize_if.sv
// Port bundle for the FP MAC post-accumulate normalization stage.
// The master side drives accumulator data and flag clear; the slave side returns the result.
interface fr_normalize_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_sign;
    logic [8:0]       in_exp;
    logic             in_carry;
    logic [23:0]      in_mant;
    logic [7:0]       lod_count;
    logic             flag_clr;
    logic             out_valid;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             sticky_ovf;
    logic             sticky_unf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_sign, in_exp, in_carry, in_mant, lod_count, flag_clr,
        input  out_valid, out_result, out_zero, sticky_ovf, sticky_unf, out_count
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_carry, in_mant, lod_count, flag_clr,
        output out_valid, out_result, out_zero, sticky_ovf, sticky_unf, out_count
    );
endinterface

// File: rtl/fr_normalize.sv
// Two-stage normalization of the MAC accumulator into a packed IEEE-754 single.
// Define FR_ROUND_EN to round-to-nearest-even the carry-out path instead of truncating.
module fr_normalize #(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clock,
    input  logic          resetn,
    fr_normalize_if.slave bus
);

    logic             s1_valid;
    logic             s1_sign;
    logic [8:0]       s1_exp;
    logic             s1_carry;
    logic [23:0]      s1_mant;

    logic             valid_q;
    logic [31:0]      result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             unf_q;
    logic [CNT_W-1:0] count_q;

    logic [7:0]         lod_sat;
    logic [4:0]         shift;
    logic [22:0]        frac;
    logic signed [10:0] e;
    logic               is_zero;
    logic               ovf_ev;
    logic               unf_ev;
    logic [31:0]        result_d;

    always_comb begin
        lod_sat  = (bus.lod_count > 8'd23) ? 8'd23 : bus.lod_count;
        shift    = 5'(8'd23 - lod_sat);
        frac     = '0;
        // One bit of headroom beyond 10 so exp=511 with carry cannot wrap negative.
        e        = '0;
        is_zero  = 1'b0;
        ovf_ev   = 1'b0;
        unf_ev   = 1'b0;
        result_d = '0;

        if (s1_carry) begin
            frac = s1_mant[23:1];
            e    = $signed({2'b00, s1_exp}) + 11'sd1;
`ifdef FR_ROUND_EN
            // Tie with sticky=0: bump only when the kept LSB is odd.
            if (s1_mant[0] && frac[0]) begin
                if (&frac) begin
                    frac = '0;
                    e    = e + 11'sd1;
                end else begin
                    frac = frac + 23'd1;
                end
            end
`endif
        end else if (s1_mant == 24'd0) begin
            is_zero = 1'b1;
        end else begin
            frac = 23'(s1_mant << shift);
            e    = $signed({2'b00, s1_exp}) - $signed({6'b000000, shift});
        end

        if (is_zero) begin
            result_d = {s1_sign, 31'b0};
        end else if (e >= 11'sd255) begin
            result_d = {s1_sign, 8'hFF, 23'b0};
            ovf_ev   = 1'b1;
        end else if (e <= 11'sd0) begin
            result_d = {s1_sign, 31'b0};
            unf_ev   = 1'b1;
            is_zero  = 1'b1;
        end else begin
            result_d = {s1_sign, e[7:0], frac};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_carry <= 1'b0;
            s1_mant  <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign  <= bus.in_sign;
                s1_exp   <= bus.in_exp;
                s1_carry <= bus.in_carry;
                s1_mant  <= bus.in_mant;
            end

            valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= result_d;
                zero_q   <= is_zero;
            end

            if (s1_valid && ovf_ev) begin
                ovf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                ovf_q <= 1'b0;
            end

            if (s1_valid && unf_ev) begin
                unf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                unf_q <= 1'b0;
            end

            if (s1_valid && !(&count_q)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.sticky_ovf = ovf_q;
    assign bus.sticky_unf = unf_q;
    assign bus.out_count  = count_q;

endmodule

// File: tb/tb_fr_normalize.sv
// Directed vector bench for fr_normalize: table of single results plus
// hand-written sequences for sticky flags, back-to-back streaming and mid-flight reset.
module tb_fr_normalize;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    fr_normalize_if #(.CNT_W(16)) bus ();

    fr_normalize #(.CNT_W(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        sign;
        logic [8:0]  exp;
        logic        carry;
        logic [23:0] mant;
        logic [7:0]  lod;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_carry  = 1'b0;
        bus.in_mant   = '0;
        bus.lod_count = 8'd23;
        bus.flag_clr  = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_carry = v.carry;
        bus.in_mant  = v.mant;
    endtask

    // Drive one vector, feed its detector count a cycle later, check two edges on.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clock);
        drive_vec(v);
        bus.flag_clr = 1'b1;
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.flag_clr  = 1'b0;
        bus.lod_count = v.lod;
        @(negedge clock);
        check($sformatf("v%0d valid", idx), 32'(bus.out_valid), 32'd1);
        check($sformatf("v%0d result", idx), bus.out_result, v.result);
        check($sformatf("v%0d zero", idx), 32'(bus.out_zero), 32'(v.zero));
        check($sformatf("v%0d ovf", idx), 32'(bus.sticky_ovf), 32'(v.ovf));
        check($sformatf("v%0d unf", idx), 32'(bus.sticky_unf), 32'(v.unf));
        @(negedge clock);
        check($sformatf("v%0d valid drop", idx), 32'(bus.out_valid), 32'd0);
    endtask

    vec_t b2b [3];
    vec_t uv;

    initial begin
        //          sign exp   c  mant        lod     result        z  o  u
        vecs[0]  = '{1'b0, 9'd127, 1'b0, 24'h400000, 8'd22,  32'h3F000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 9'd127, 1'b1, 24'h800000, 8'd0,   32'h40400000, 1'b0, 1'b0, 1'b0};
`ifdef FR_ROUND_EN
        vecs[2]  = '{1'b0, 9'd127, 1'b1, 24'hC00003, 8'd0,   32'h40600002, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 9'd127, 1'b1, 24'hFFFFFF, 8'd0,   32'h40800000, 1'b0, 1'b0, 1'b0};
`else
        vecs[2]  = '{1'b0, 9'd127, 1'b1, 24'hC00003, 8'd0,   32'h40600001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 9'd127, 1'b1, 24'hFFFFFF, 8'd0,   32'h407FFFFF, 1'b0, 1'b0, 1'b0};
`endif
        vecs[3]  = '{1'b1, 9'd100, 1'b0, 24'h000000, 8'd23,  32'h80000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd10,  1'b0, 24'h000001, 8'd0,   32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 9'd254, 1'b1, 24'h800000, 8'd0,   32'h7F800000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 9'd130, 1'b0, 24'h000123, 8'd8,   32'hB9918000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 9'd127, 1'b0, 24'h800000, 8'd200, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 9'd1,   1'b0, 24'h400000, 8'd22,  32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 9'd1,   1'b0, 24'h800000, 8'd23,  32'h00800000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 9'd254, 1'b0, 24'hFFFFFF, 8'd23,  32'h7F7FFFFF, 1'b0, 1'b0, 1'b0};

        b2b[0] = '{1'b0, 9'd127, 1'b1, 24'h800000, 8'd0, 32'h40400000, 1'b0, 1'b0, 1'b0};
        b2b[1] = '{1'b0, 9'd128, 1'b1, 24'h800000, 8'd0, 32'h40C00000, 1'b0, 1'b0, 1'b0};
        b2b[2] = '{1'b0, 9'd126, 1'b1, 24'h800000, 8'd0, 32'h3FC00000, 1'b0, 1'b0, 1'b0};
        uv     = vecs[4];

        drive_idle();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.out_result, 32'd0);
        check("reset zero", 32'(bus.out_zero), 32'd0);
        check("reset ovf", 32'(bus.sticky_ovf), 32'd0);
        check("reset unf", 32'(bus.sticky_unf), 32'd0);
        check("reset count", 32'(bus.out_count), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("post-reset valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end
        check("count after table", 32'(bus.out_count), 32'd12);

        // Underflow with flag_clr on the event edge: set must win.
        @(negedge clock);
        drive_vec(uv);
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.lod_count = uv.lod;
        bus.flag_clr  = 1'b1;
        @(negedge clock);
        bus.flag_clr = 1'b0;
        check("unf set beats clr", 32'(bus.sticky_unf), 32'd1);
        @(negedge clock);
        bus.flag_clr = 1'b1;
        @(negedge clock);
        bus.flag_clr = 1'b0;
        check("unf cleared", 32'(bus.sticky_unf), 32'd0);

        // Back-to-back stream from a fresh counter.
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i >= 2 && i <= 4) begin
                check($sformatf("b2b%0d valid", i - 2), 32'(bus.out_valid), 32'd1);
                check($sformatf("b2b%0d result", i - 2), bus.out_result, b2b[i-2].result);
            end
            if (i == 5) begin
                check("b2b tail valid", 32'(bus.out_valid), 32'd0);
                check("b2b count", 32'(bus.out_count), 32'd3);
            end
            if (i < 3) drive_vec(b2b[i]);
            else bus.in_valid = 1'b0;
        end

        // Reset while a result sits in stage 1.
        @(negedge clock);
        drive_vec(b2b[0]);
        @(negedge clock);
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("midreset valid", 32'(bus.out_valid), 32'd0);
        check("midreset count", 32'(bus.out_count), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("after release valid%0d", i), 32'(bus.out_valid), 32'd0);
        end
        check("after release count", 32'(bus.out_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
